// File: rtl/scan_pkg.sv
// Shared definitions for the channel scanner: channel count, select width
// and the two-state controller encoding.
package scan_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
endpackage

// File: rtl/channel_scanner_next_channel.sv
// Rotating-priority search for the next enabled channel, starting at sel
// (inclusive) or just after it (exclusive), with modulo-NUM_CH wrap.
module next_channel
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [NUM_CH-1:0] mask,
    input  logic              inclusive,
    output logic [SEL_W-1:0]  next,
    output logic              found,
    output logic              wrapped
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        next    = sel;
        found   = 1'b0;
        wrapped = 1'b0;
        cand    = sel;
        // Walk from the farthest offset down so the nearest hit is the last write.
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = sel + SEL_W'(inclusive ? k - 1 : k);
            if (mask[cand]) begin
                next  = cand;
                found = 1'b1;
            end
        end
        wrapped = found && (next <= sel);
    end

endmodule

// File: rtl/channel_scanner.sv
// Channel scanner: dwells dwell+1 cycles on each enabled channel while en is
// high, and supports single-step manual advance while idle.
module channel_scanner
    import scan_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    input  logic               step,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               tick,
    output logic               wrap
);

    state_t             state, state_nx;
    logic [DWELL_W-1:0] presc, presc_nx;
    logic [SEL_W-1:0]   sel_nx;
    logic               tick_nx, wrap_nx;

    logic [SEL_W-1:0]   inc_next, exc_next;
    logic               inc_found, exc_found;
    logic               inc_wrapped, exc_wrapped;
    logic               mask_any;

    assign mask_any = |mask;

    next_channel u_search_incl (
        .sel       (sel),
        .mask      (mask),
        .inclusive (1'b1),
        .next      (inc_next),
        .found     (inc_found),
        .wrapped   (inc_wrapped)
    );

    next_channel u_search_excl (
        .sel       (sel),
        .mask      (mask),
        .inclusive (1'b0),
        .next      (exc_next),
        .found     (exc_found),
        .wrapped   (exc_wrapped)
    );

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        sel_nx   = sel;
        tick_nx  = 1'b0;
        wrap_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && mask_any) begin
                    state_nx = SCAN;
                    presc_nx = '0;
                    if (inc_found && (inc_next != sel)) begin
                        sel_nx  = inc_next;
                        tick_nx = 1'b1;
                        wrap_nx = inc_wrapped;
                    end
                end else if (!en && step && mask_any && exc_found) begin
                    sel_nx  = exc_next;
                    tick_nx = 1'b1;
                    wrap_nx = exc_wrapped;
                end
            end
            SCAN: begin
                if (!en || !mask_any) begin
                    state_nx = IDLE;
                    presc_nx = '0;
                end else if (presc >= dwell) begin
                    // A lone enabled channel re-selects itself; tick and wrap still fire.
                    presc_nx = '0;
                    sel_nx   = exc_next;
                    tick_nx  = 1'b1;
                    wrap_nx  = exc_wrapped;
                end else begin
                    presc_nx = presc + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            sel   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            sel   <= sel_nx;
            tick  <= tick_nx;
            wrap  <= wrap_nx;
        end
    end

    assign sel_valid = (state == SCAN) && mask[sel];

endmodule

// File: tb/tb_channel_scanner.sv
// Scoreboard bench for channel_scanner: a behavioural model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_channel_scanner;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [7:0]    mask = '0;
    logic          step = 1'b0;
    logic [2:0]    sel;
    logic          sel_valid, tick, wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sel;
        bit tick;
        bit wrap;
        bit scanning;
    } exp_t;

    exp_t q[$];

    channel_scanner #(.DWELL_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dwell     (dwell),
        .mask      (mask),
        .step      (step),
        .sel       (sel),
        .sel_valid (sel_valid),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: channel index as an integer, dwell counted in plain cycles.
    bit m_scanning = 0;
    int m_count = 0;
    int m_sel = 0;
    bit m_started = 0;

    function automatic int find_channel(int from, logic [7:0] m, bit include_from);
        for (int k = (include_from ? 0 : 1); k <= 8; k++) begin
            if (m[(from + k) % 8]) return (from + k) % 8;
        end
        return from;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int old_sel;
        bit moved;
        if (rst) begin
            m_scanning = 0;
            m_count = 0;
            m_sel = 0;
            m_started = 1;
            e.sel = 0; e.tick = 0; e.wrap = 0; e.scanning = 0;
        end else begin
            old_sel = m_sel;
            moved = 0;
            if (m_scanning) begin
                if (!en || mask == 8'h00) begin
                    m_scanning = 0;
                    m_count = 0;
                end else if (m_count >= int'(dwell)) begin
                    m_count = 0;
                    m_sel = find_channel(m_sel, mask, 0);
                    moved = 1;
                end else begin
                    m_count++;
                end
            end else if (en && mask != 8'h00) begin
                m_scanning = 1;
                m_count = 0;
                m_sel = find_channel(m_sel, mask, 1);
                moved = (m_sel != old_sel);
            end else if (!en && step && mask != 8'h00) begin
                m_sel = find_channel(m_sel, mask, 0);
                moved = 1;
            end
            e.sel = m_sel;
            e.tick = moved;
            e.wrap = moved && (m_sel <= old_sel);
            e.scanning = m_scanning;
        end
        if (m_started) q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        bit exp_valid;
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_valid = e.scanning && mask[e.sel];
            checks++;
            if (int'(sel) != e.sel) begin
                errors++;
                $display("FAIL sel t=%0t got %0d want %0d", $time, sel, e.sel);
            end
            checks++;
            if (tick !== e.tick) begin
                errors++;
                $display("FAIL tick t=%0t got %0b want %0b", $time, tick, e.tick);
            end
            checks++;
            if (wrap !== e.wrap) begin
                errors++;
                $display("FAIL wrap t=%0t got %0b want %0b", $time, wrap, e.wrap);
            end
            checks++;
            if (sel_valid !== exp_valid) begin
                errors++;
                $display("FAIL sel_valid t=%0t got %0b want %0b", $time, sel_valid, exp_valid);
            end
        end else if (m_started) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t got 0 entries want 1", $time);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
    endtask

    initial begin
        run(2);
        rst = 1'b0;

        // Full-mask scan with dwell 2, including the 7->0 wrap.
        mask = 8'hFF; dwell = 2; en = 1'b1;
        run(30);

        // Sparse mask with dwell 0 from sel=0.
        en = 1'b0; pulse_rst();
        mask = 8'b1010_0100; dwell = 0; en = 1'b1;
        run(8);

        // Manual stepping while idle.
        en = 1'b0; pulse_rst();
        mask = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; run(1);
            step = 1'b0; run(2);
        end

        // Mask cleared mid-scan, then restored.
        pulse_rst();
        mask = 8'hFF; dwell = 3; en = 1'b1;
        run(14);
        mask = 8'h00; run(2);
        mask = 8'hFF; run(10);

        // Dwell lowered below the running count.
        dwell = 10; run(20);
        dwell = 1; run(5);

        // Reset mid-dwell with en held high.
        dwell = 4; run(3);
        pulse_rst();
        run(10);

        // Single-channel mask: every advance re-selects and wraps.
        mask = 8'h40; dwell = 1; run(8);

        // step coincident with en, and step with empty mask.
        en = 1'b0; run(1);
        mask = 8'h00; step = 1'b1; run(1);
        mask = 8'h0F; en = 1'b1; run(2);
        step = 1'b0; run(3);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = 8'h00;
                    1: mask = 8'(1 << $urandom_range(0, 7));
                    default: mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) dwell = DW'($urandom_range(0, 6));
            step = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 99) == 0);
            run(1);
        end
        rst = 1'b0; step = 1'b0; en = 1'b0;
        run(3);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_scanner.md
CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 Parameter DWELL_W, default 16, sets the width of the dwell-period input and the internal prescaler.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  level; 1 = free-running scan, 0 = idle/manual.
REQ-005 dwell  input  DWELL_W  each channel is held for dwell+1 cycles.
REQ-006 mask  input  8  channel enable bitmap; bit i enables channel i.
REQ-007 step  input  1  single-cycle pulse; manual advance while idle.
REQ-008 sel  output  3  current channel index; drives the 3-to-8 decoder select input directly.
REQ-009 sel_valid  output  1  high when the state is SCAN and mask[sel]=1.
REQ-010 tick  output  1  one-cycle pulse in the same cycle that sel takes a new value.
REQ-011 wrap  output  1  one-cycle pulse, coincident with tick, when the new sel is numerically <= the old sel.

Function
REQ-012 The block SHALL have states IDLE and SCAN.
REQ-013 Transition from IDLE to SCAN:
  - Occurs when en=1 and mask!=0.
  - On entry, sel loads the first enabled channel at or after the current sel, searching with modulo-8 wrap.
  - On entry, the prescaler clears to 0.
  - tick pulses on entry only if sel changes.
REQ-014 In SCAN, the prescaler SHALL increment each cycle.
  - When prescaler>=dwell, the block advances: prescaler clears and sel loads the next enabled channel strictly after sel, with modulo-8 wrap.
  - Each advance produces a tick pulse.
REQ-015 dwell=0 SHALL advance sel every cycle; any dwell change takes effect at the next compare, using >= so that lowering dwell below the current count advances on the next cycle.
REQ-016 If exactly one mask bit is set, an advance SHALL reload the same sel, pulse tick, and pulse wrap.
REQ-017 In SCAN, en=0 or mask=0 SHALL return the block to IDLE next cycle.
  - sel is held.
  - The prescaler clears.
  - No tick is produced.
REQ-018 A step pulse in IDLE with mask!=0 SHALL advance sel to the next enabled channel the following cycle, with tick and wrap as in REQ-011.
  - step SHALL be ignored in SCAN.
  - step SHALL be ignored when mask=0.
  - step SHALL be ignored in the same cycle that en=1 (en wins).
REQ-019 Clearing mask[sel] mid-dwell SHALL drop sel_valid immediately (combinational from registered sel and state) and SHALL NOT shorten the dwell.
REQ-020 tick and wrap SHALL be registered outputs; sel SHALL never take an out-of-range value.

Reset
REQ-021 While rst=1 at a clock edge, the next state SHALL be:
  - state = IDLE, prescaler = 0, sel = 0.
  - tick = 0, wrap = 0, so sel_valid = 0.
REQ-022 Reset SHALL override en and step in the same cycle and SHALL abort any dwell in progress.

Structure
REQ-023 Shared package scan_pkg SHALL hold:
  - NUM_CH=8 and SEL_W=3.
  - The state encoding (IDLE=0, SCAN=1).
REQ-024 Sub-module next_channel SHALL be purely combinational, one instance per search mode, with:
  - Inputs: sel, mask, inclusive flag.
  - Outputs: next index, found flag, wrapped flag.
  - Behaviour: rotating-priority search.

Verification
REQ-025 Reset, then mask=8'hFF, dwell=2, en=1 -> sel steps 0,1,...,7,0, each value held 3 cycles; tick on every change; wrap only on the 7->0 change.
REQ-026 mask=8'b1010_0100, dwell=0, en=1 from sel=0 -> entry sel=2, then 5,7,2,5 on consecutive cycles; wrap on 7->2.
REQ-027 en=0, mask=8'h11, three step pulses from sel=0 -> sel 4,0,4; tick on each; wrap on 4->0 only; sel_valid=0 throughout.
REQ-028 Scanning mask=8'hFF, dwell=3; set mask=0 at sel=3 -> next cycle IDLE, sel=3, sel_valid=0; restore 8'hFF -> SCAN resumes at sel=3 with a full 4-cycle dwell.
REQ-029 dwell=10, prescaler=6, sel=1, then dwell set to 1 -> sel=2 and tick on the next cycle.
REQ-030 rst pulsed mid-dwell at sel=5 with en=1 -> next cycle sel=0, tick=0, wrap=0, sel_valid=0; after rst drops, SCAN starts at sel=0.
